// File: rtl/rv32i_csr_unit.sv
// rv32i_csr_unit: machine-mode CSR file, counters, trap entry and MRET.
// Ports: clk, rst (sync, high); csr_valid/op/addr/wdata -> csr_rdata,
//        csr_illegal; retire; trap_req/pc/cause/tval; mret ->
//        redirect_valid/redirect_pc; priv (always machine mode).

package rv32i_csr_pkg;
    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        PV_USER       = 2'b00,
        PV_SUPERVISOR = 2'b01,
        PV_MACHINE    = 2'b11
    } privilege_level_e;
endpackage

module rv32i_csr_unit
    import rv32i_csr_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned COUNTER_W   = 64,
    parameter int unsigned HART_ID     = 0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_valid,
    input  csr_op_e          csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [XLEN-1:0]  csr_wdata,
    output logic [XLEN-1:0]  csr_rdata,
    output logic             csr_illegal,
    input  logic             retire,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic [XLEN-1:0]  trap_cause,
    input  logic [XLEN-1:0]  trap_tval,
    input  logic             mret,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output privilege_level_e priv
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic                 mstatus_mie;
    logic                 mstatus_mpie;
    logic [XLEN-1:0]      mie_q;
    logic [XLEN-1:0]      mtvec_q;
    logic [XLEN-1:0]      mscratch_q;
    logic [XLEN-1:0]      mepc_q;
    logic [XLEN-1:0]      mcause_q;
    logic [XLEN-1:0]      mtval_q;
    logic [COUNTER_W-1:0] mcycle_q;
    logic [COUNTER_W-1:0] minstret_q;

    logic [63:0]     cyc_ext;
    logic [63:0]     ins_ext;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_tgt;
    logic            impl;
    logic            wr_req;
    logic            do_write;

    // Counters viewed as 64 bits so high halves zero-extend for any width.
    assign cyc_ext = 64'(mcycle_q);
    assign ins_ext = 64'(minstret_q);

    assign mstatus_val = XLEN'({19'd0, 2'b11, 3'd0, mstatus_mpie,
                                3'd0, mstatus_mie, 3'd0});

    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        unique case (csr_addr)
            A_MSTATUS:               old_val = mstatus_val;
            A_MISA:                  old_val = XLEN'(32'h4000_0100);
            A_MIE:                   old_val = mie_q;
            A_MTVEC:                 old_val = mtvec_q;
            A_MSCRATCH:              old_val = mscratch_q;
            A_MEPC:                  old_val = mepc_q;
            A_MCAUSE:                old_val = mcause_q;
            A_MTVAL:                 old_val = mtval_q;
            A_MIP:                   old_val = '0;
            A_MCYCLE,   A_CYCLE:     old_val = cyc_ext[31:0];
            A_MCYCLEH,  A_CYCLEH:    old_val = cyc_ext[63:32];
            A_MINSTRET, A_INSTRET:   old_val = ins_ext[31:0];
            A_MINSTRETH, A_INSTRETH: old_val = ins_ext[63:32];
            A_MHARTID:               old_val = XLEN'(HART_ID);
            default:                 impl    = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read.
    assign wr_req = (csr_op == CSR_RW) ||
                    (((csr_op == CSR_RS) || (csr_op == CSR_RC)) &&
                     (csr_wdata != '0));

    assign csr_illegal = csr_valid &&
                         (!impl || ((csr_addr[11:10] == 2'b11) && wr_req));

    assign csr_rdata = (csr_valid && !csr_illegal) ? old_val : '0;

    assign do_write = csr_valid && !csr_illegal && wr_req &&
                      !trap_req && !mret;

    always_comb begin
        new_val = old_val;
        unique case (csr_op)
            CSR_NOP: new_val = old_val;
            CSR_RW:  new_val = csr_wdata;
            CSR_RS:  new_val = old_val | csr_wdata;
            CSR_RC:  new_val = old_val & ~csr_wdata;
        endcase
    end

    // Vectored mode only applies to interrupts (cause MSB set).
    assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_tgt  = (mtvec_q[0] && trap_cause[XLEN-1]) ?
                       trap_base + {trap_cause[XLEN-3:0], 2'b00} :
                       trap_base;

    assign priv = PV_MACHINE;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie    <= 1'b0;
            mstatus_mpie   <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= XLEN'(MTVEC_RESET) & ~XLEN'(2);
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            mcycle_q       <= mcycle_q + 1'b1;
            redirect_valid <= 1'b0;
            if (retire) begin
                minstret_q <= minstret_q + 1'b1;
            end
            if (trap_req) begin
                mepc_q         <= trap_pc & ~XLEN'(3);
                mcause_q       <= trap_cause;
                mtval_q        <= trap_tval;
                mstatus_mpie   <= mstatus_mie;
                mstatus_mie    <= 1'b0;
                redirect_valid <= 1'b1;
                redirect_pc    <= trap_tgt;
            end else if (mret) begin
                mstatus_mie    <= mstatus_mpie;
                mstatus_mpie   <= 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= mepc_q;
            end else if (do_write) begin
                // Counter writes come last so they beat the increment.
                unique case (csr_addr)
                    A_MSTATUS: begin
                        mstatus_mie  <= new_val[3];
                        mstatus_mpie <= new_val[7];
                    end
                    A_MIE:      mie_q      <= new_val;
                    A_MTVEC:    mtvec_q    <= new_val & ~XLEN'(2);
                    A_MSCRATCH: mscratch_q <= new_val;
                    A_MEPC:     mepc_q     <= new_val & ~XLEN'(3);
                    A_MCAUSE:   mcause_q   <= new_val;
                    A_MTVAL:    mtval_q    <= new_val;
                    A_MCYCLE:
                        mcycle_q <= COUNTER_W'({cyc_ext[63:32], new_val});
                    A_MCYCLEH:
                        mcycle_q <= COUNTER_W'({new_val, cyc_ext[31:0]});
                    A_MINSTRET:
                        minstret_q <= COUNTER_W'({ins_ext[63:32], new_val});
                    A_MINSTRETH:
                        minstret_q <= COUNTER_W'({new_val, ins_ext[31:0]});
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_csr_unit.sv
// tb_rv32i_csr_unit: directed checks of the CSR unit.
// Drives inputs 1ns after the rising edge, samples mid-cycle.

module tb_rv32i_csr_unit;
    import rv32i_csr_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             csr_valid;
    csr_op_e          csr_op;
    logic [11:0]      csr_addr;
    logic [31:0]      csr_wdata;
    logic [31:0]      csr_rdata;
    logic             csr_illegal;
    logic             retire;
    logic             trap_req;
    logic [31:0]      trap_pc;
    logic [31:0]      trap_cause;
    logic [31:0]      trap_tval;
    logic             mret;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    privilege_level_e priv;

    int          n_run;
    int          n_fail;
    logic [63:0] ncyc;
    logic [31:0] d;
    logic        ill;

    always #5 clk = ~clk;

    rv32i_csr_unit #(
        .XLEN       (32),
        .COUNTER_W  (64),
        .HART_ID    (5),
        .MTVEC_RESET(32'h0000_0042)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_valid     (csr_valid),
        .csr_op        (csr_op),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .csr_illegal   (csr_illegal),
        .retire        (retire),
        .trap_req      (trap_req),
        .trap_pc       (trap_pc),
        .trap_cause    (trap_cause),
        .trap_tval     (trap_tval),
        .mret          (mret),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .priv          (priv)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) ncyc = 0;
        else     ncyc = ncyc + 1;
        #1;
    endtask

    task automatic idle();
        csr_valid = 1'b0;
        csr_op    = CSR_NOP;
        csr_addr  = 12'h0;
        csr_wdata = 32'h0;
        trap_req  = 1'b0;
        mret      = 1'b0;
        retire    = 1'b0;
    endtask

    task automatic acc(input csr_op_e op, input logic [11:0] a,
                       input logic [31:0] w,
                       output logic [31:0] rd_v, output logic ill_v);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = w;
        #1;
        rd_v  = csr_rdata;
        ill_v = csr_illegal;
    endtask

    task automatic rd(input logic [11:0] a,
                      output logic [31:0] rd_v, output logic ill_v);
        acc(CSR_RS, a, 32'h0, rd_v, ill_v);
        csr_valid = 1'b0;
        csr_op    = CSR_NOP;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        ncyc = 0;
        idle();
        trap_pc = 0;
        trap_cause = 0;
        trap_tval = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        rd(12'hB00, d, ill);
        chk("rst_mcycle", d, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("priv", priv, 2'b11);
        rd(12'h305, d, ill);
        chk("rst_mtvec", d, 32'h40);
        rd(12'h300, d, ill);
        chk("rst_mstatus", d, 32'h1800);

        repeat (10) tick();
        rd(12'hB00, d, ill);
        chk("cyc10", d, 10);
        chk("cyc10_ill", ill, 0);
        rd(12'hC80, d, ill);
        chk("cycleh0", d, 0);

        acc(CSR_RW, 12'h340, 32'hA5A5_0000, d, ill);
        chk("ms_rw_old", d, 0);
        tick(); idle();
        acc(CSR_RS, 12'h340, 32'h0000_00FF, d, ill);
        chk("ms_rs_old", d, 32'hA5A5_0000);
        tick(); idle();
        acc(CSR_RC, 12'h340, 32'hA000_000F, d, ill);
        chk("ms_rc_old", d, 32'hA5A5_00FF);
        tick(); idle();
        rd(12'h340, d, ill);
        chk("ms_final", d, 32'h05A5_00F0);

        acc(CSR_RW, 12'hC00, 32'h1, d, ill);
        chk("c00_ill", ill, 1);
        chk("c00_rdata", d, 0);
        tick(); idle();
        rd(12'hC00, d, ill);
        chk("c00_rs0_ill", ill, 0);
        chk("c00_rs0", d, ncyc[31:0]);
        rd(12'hB00, d, ill);
        chk("mcycle_kept", d, ncyc[31:0]);
        rd(12'h7C0, d, ill);
        chk("unimpl_ill", ill, 1);
        chk("unimpl_rd", d, 0);
        rd(12'hF14, d, ill);
        chk("mhartid", d, 5);

        acc(CSR_RW, 12'hF14, 32'h9, d, ill);
        chk("hartid_wr_ill", ill, 1);
        tick(); idle();
        acc(CSR_RW, 12'h301, 32'h0, d, ill);
        chk("misa_wr_ill", ill, 0);
        tick(); idle();
        rd(12'h301, d, ill);
        chk("misa", d, 32'h4000_0100);
        acc(CSR_RW, 12'h344, 32'hFFFF_FFFF, d, ill);
        tick(); idle();
        rd(12'h344, d, ill);
        chk("mip", d, 0);

        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        rd(12'hB02, d, ill);
        chk("minstret3", d, 3);

        acc(CSR_RW, 12'h305, 32'h8000_0101, d, ill);
        tick(); idle();
        rd(12'h305, d, ill);
        chk("mtvec", d, 32'h8000_0101);
        acc(CSR_RW, 12'h300, 32'h0000_0008, d, ill);
        tick(); idle();
        rd(12'h300, d, ill);
        chk("mstatus_mie", d, 32'h1808);

        trap_req = 1'b1;
        trap_pc = 32'h0000_1236;
        trap_cause = 32'h8000_0007;
        trap_tval = 32'h0000_DEAD;
        retire = 1'b1;
        tick(); idle();
        chk("trap_rv", redirect_valid, 1);
        chk("trap_rpc", redirect_pc, 32'h8000_011C);
        rd(12'h341, d, ill);
        chk("trap_mepc", d, 32'h1234);
        rd(12'h342, d, ill);
        chk("trap_mcause", d, 32'h8000_0007);
        rd(12'h343, d, ill);
        chk("trap_mtval", d, 32'hDEAD);
        rd(12'h300, d, ill);
        chk("trap_mstatus", d, 32'h1880);
        rd(12'hB02, d, ill);
        chk("trap_retire", d, 4);
        tick();
        chk("rv_one_cycle", redirect_valid, 0);

        mret = 1'b1;
        tick(); idle();
        chk("mret_rv", redirect_valid, 1);
        chk("mret_rpc", redirect_pc, 32'h1234);
        rd(12'h300, d, ill);
        chk("mret_mstatus", d, 32'h1888);

        trap_req = 1'b1;
        mret = 1'b1;
        trap_pc = 32'h0000_2000;
        trap_cause = 32'h0000_0002;
        trap_tval = 32'h0;
        acc(CSR_RW, 12'h340, 32'h1234_5678, d, ill);
        chk("prio_rdata", d, 32'h05A5_00F0);
        tick(); idle();
        chk("prio_rv", redirect_valid, 1);
        chk("prio_rpc", redirect_pc, 32'h8000_0100);
        rd(12'h340, d, ill);
        chk("prio_mscratch", d, 32'h05A5_00F0);
        rd(12'h341, d, ill);
        chk("prio_mepc", d, 32'h2000);
        rd(12'h300, d, ill);
        chk("prio_mstatus", d, 32'h1880);
        mret = 1'b1;
        tick(); idle();
        chk("b2b_rv", redirect_valid, 1);
        chk("b2b_rpc", redirect_pc, 32'h2000);
        tick();
        chk("b2b_end_rv", redirect_valid, 0);

        trap_req = 1'b1;
        trap_pc = 32'h0000_3000;
        tick();
        chk("pre_rst_rv", redirect_valid, 1);
        rst = 1'b1;
        mret = 1'b1;
        acc(CSR_RW, 12'h340, 32'hFFFF, d, ill);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_ovr_rv", redirect_valid, 0);
        chk("rst_ovr_rpc", redirect_pc, 0);
        rd(12'h340, d, ill);
        chk("rst_ovr_mscratch", d, 0);
        rd(12'h341, d, ill);
        chk("rst_ovr_mepc", d, 0);
        rd(12'h300, d, ill);
        chk("rst_ovr_mstatus", d, 32'h1800);

        acc(CSR_RW, 12'hB00, 32'hFFFF_FFFF, d, ill);
        tick(); idle();
        acc(CSR_RW, 12'hB80, 32'h0, d, ill);
        tick(); idle();
        tick();
        rd(12'hB80, d, ill);
        chk("wrap_hi", d, 1);
        rd(12'hB00, d, ill);
        chk("wrap_lo", d, 0);

        acc(CSR_RW, 12'hB82, 32'h7, d, ill);
        tick(); idle();
        rd(12'hC82, d, ill);
        chk("instreth", d, 7);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
